// File: rtl/fetch_sequencer_pkg.sv
// Shared types and pc_mode encodings for the instruction-fetch controller and pc-side benches.
package fetch_sequencer_pkg;

    localparam logic [2:0] PC_MODE_RESET = 3'd0;
    localparam logic [2:0] PC_MODE_LOAD  = 3'd1;
    localparam logic [2:0] PC_MODE_HOLD  = 3'd3;
    localparam logic [2:0] PC_MODE_INC   = 3'd4;

    typedef enum logic [2:0] {
        S_RST   = 3'd0,
        S_FETCH = 3'd1,
        S_INC   = 3'd2,
        S_WAIT  = 3'd3,
        S_JUMP  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    // pc_mode presented to the pc block while in a given state
    function automatic logic [2:0] pc_mode_of(input state_t s);
        case (s)
            S_RST:   return PC_MODE_RESET;
            S_JUMP:  return PC_MODE_LOAD;
            S_INC:   return PC_MODE_INC;
            default: return PC_MODE_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/fetch_sequencer_queue.sv
// Two-entry FIFO of {instr, instr_pc} with flush; head entry is always storage slot 0.
module fetch_queue #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_instr,
    input  logic [WIDTH-1:0] push_pc,
    output logic [WIDTH-1:0] head_instr,
    output logic [WIDTH-1:0] head_pc,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] instr_q [2];
    logic [WIDTH-1:0] pc_q    [2];
    logic             pop_ok;
    logic             push_ok;
    logic [1:0]       wr_slot;

    assign pop_ok  = pop && (count != 2'd0);
    assign push_ok = push && ((count != 2'd2) || pop_ok);
    assign wr_slot = count - 2'(pop_ok);

    assign head_instr = instr_q[0];
    assign head_pc    = pc_q[0];
    assign full       = (count == 2'd2);
    assign empty      = (count == 2'd0);

    // Pop shifts slot 1 down; a same-cycle push into slot 0 overrides that shift
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count      <= 2'd0;
            instr_q[0] <= '0;
            instr_q[1] <= '0;
            pc_q[0]    <= '0;
            pc_q[1]    <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            if (pop_ok) begin
                instr_q[0] <= instr_q[1];
                pc_q[0]    <= pc_q[1];
            end
            if (push_ok) begin
                if (wr_slot == 2'd0) begin
                    instr_q[0] <= push_instr;
                    pc_q[0]    <= push_pc;
                end else begin
                    instr_q[1] <= push_instr;
                    pc_q[1]    <= push_pc;
                end
            end
            count <= count + 2'(push_ok) - 2'(pop_ok);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: steers the pc, reads program memory, queues bytes for the decoder.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pc_value,
    output logic [2:0]       pc_mode,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_oe,
    output logic             mem_rd,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_data,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             jump_req,
    input  logic [WIDTH-1:0] jump_target,
    output logic             jump_ack,
    output logic             fetch_err
);

    localparam int unsigned        TIMER_W    = $clog2(ACK_TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ACK_TIMEOUT - 1);

    state_t             state;
    state_t             state_next;
    logic [TIMER_W-1:0] timer;
    logic               pop;
    logic               push;
    logic               flush;
    logic [1:0]         q_count;
    logic               q_full;
    logic               q_empty;
    logic               full_after_pop;

    assign instr_valid    = !q_empty;
    assign pop            = instr_valid && instr_ready;
    assign full_after_pop = ((q_count - 2'(pop)) == 2'd2);
    assign push           = (state == S_FETCH) && !jump_req && mem_ack && (!q_full || pop);
    assign flush          = (state_next == S_JUMP);

    always_comb begin
        state_next = state;
        case (state)
            S_RST:   state_next = S_FETCH;
            S_FETCH: begin
                if (jump_req)                 state_next = S_JUMP;
                else if (mem_ack)             state_next = S_INC;
                else if (timer == TIMER_LAST) state_next = S_ERR;
            end
            S_INC: begin
                if (jump_req)            state_next = S_JUMP;
                else if (full_after_pop) state_next = S_WAIT;
                else                     state_next = S_FETCH;
            end
            S_WAIT: begin
                if (jump_req)             state_next = S_JUMP;
                else if (!full_after_pop) state_next = S_FETCH;
            end
            S_JUMP:  state_next = S_FETCH;
            S_ERR:   state_next = S_ERR;
            default: state_next = S_RST;
        endcase
    end

    // Moore outputs are registered from the next state so they line up with the state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_RST;
            timer     <= '0;
            fetch_err <= 1'b0;
            pc_mode   <= PC_MODE_RESET;
            mem_rd    <= 1'b0;
            bus_oe    <= 1'b0;
            jump_ack  <= 1'b0;
            bus_out   <= '0;
        end else begin
            state    <= state_next;
            pc_mode  <= pc_mode_of(state_next);
            mem_rd   <= (state_next == S_FETCH);
            bus_oe   <= (state_next == S_JUMP);
            jump_ack <= (state_next == S_JUMP);
            timer    <= (state == S_FETCH && state_next == S_FETCH) ? TIMER_W'(timer + 1'b1) : '0;
            if (state_next == S_JUMP) begin
                bus_out <= jump_target;
            end
            if (state == S_FETCH && state_next == S_ERR) begin
                fetch_err <= 1'b1;
            end
        end
    end

    fetch_queue #(
        .WIDTH(WIDTH)
    ) u_queue (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .push_instr (mem_data),
        .push_pc    (pc_value),
        .head_instr (instr),
        .head_pc    (instr_pc),
        .count      (q_count),
        .full       (q_full),
        .empty      (q_empty)
    );

endmodule
